mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl_pkg.sv | 17 +
 rtl/mux_scan_ctrl_settle_timer.sv | 29 ++
 rtl/mux_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared encodings and sizes for the mux scan controller.
package mux_scan_ctrl_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Down-counter that measures the settle time after each select change.
// zero is high on the last settle cycle, so the FSM can leave SETTLE on it.
module settle_timer
    import mux_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority; counting stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans an external 8-to-1 mux: steps mux_sel through 0..7, waits for the
// mux output to settle on each code, samples mux_y and publishes a complete
// 8-bit snapshot on data with a one-cycle valid pulse.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             mux_y,
    output logic [SEL_W-1:0] mux_sel,
    output logic [N_CH-1:0]  data,
    output logic             valid,
    output logic             changed,
    output logic             busy
);

    // With no settle time, each channel goes straight to SAMPLE. Otherwise
    // the timer is loaded with SETTLE_CYCLES-1 so zero marks the last cycle.
    localparam bit               SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        SKIP_SETTLE ? '0 : CNT_W'(SETTLE_CYCLES - 1);
    localparam scan_state_t      CH_ENTRY    = SKIP_SETTLE ? SAMPLE : SETTLE;

    scan_state_t     state_q, state_d;
    logic            tmr_load, tmr_en, tmr_zero;
    logic [N_CH-1:0] shadow;
    logic [N_CH-1:0] snap;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (SETTLE_LOAD),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and timer control.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CH_ENTRY;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (mux_sel == LAST_SEL) begin
                    state_d = DONE;
                end else begin
                    state_d  = CH_ENTRY;
                    tmr_load = 1'b1;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_d  = CH_ENTRY;
                    tmr_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot including the bit being sampled this cycle, so data can be
    // updated on the same edge that enters DONE.
    always_comb begin
        snap          = shadow;
        snap[mux_sel] = mux_y;
    end

    // Select stepping, shadow capture and registered snapshot outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_sel <= '0;
            shadow  <= '0;
            data    <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else begin
            valid   <= 1'b0;
            changed <= 1'b0;
            case (state_q)
                SAMPLE: begin
                    shadow[mux_sel] <= mux_y;
                    if (mux_sel == LAST_SEL) begin
                        data    <= snap;
                        valid   <= 1'b1;
                        changed <= (snap != data);
                    end else begin
                        mux_sel <= mux_sel + 1'b1;
                    end
                end
                IDLE, DONE: mux_sel <= '0;
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with SETTLE_CYCLES=2, one with 0.
// The reference model derives expected timing and data from the scan rules:
// channel i is sampled at the end of scan cycle (i+1)*(S+1), valid lands on
// scan cycle 8*(S+1)+1.
module tb_mux_scan_ctrl;

    localparam int SA = 2;
    localparam int SB = 0;
    localparam int LA = 8 * (SA + 1) + 1;
    localparam int LB = 8 * (SB + 1) + 1;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       start_a, start_b, cont_a, cont_b;
    logic [7:0] pat_a, pat_b;
    logic       y_a, y_b;
    logic [2:0] sel_a, sel_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, chg_a, chg_b, busy_a, busy_b;

    int         nchk = 0;
    int         nfail = 0;
    logic [7:0] prev_a = 8'h00;

    always #5 clk = ~clk;

    // External mux models.
    assign y_a = pat_a[sel_a];
    assign y_b = pat_b[sel_b];

    mux_scan_ctrl #(.SETTLE_CYCLES(SA)) dut_a (
        .clk(clk), .rst_n(rst_a), .start(start_a), .continuous(cont_a),
        .mux_y(y_a), .mux_sel(sel_a), .data(data_a), .valid(valid_a),
        .changed(chg_a), .busy(busy_a)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(SB)) dut_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .continuous(cont_b),
        .mux_y(y_b), .mux_sel(sel_b), .data(data_b), .valid(valid_b),
        .changed(chg_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle cycles on A: nothing must move.
    task automatic idle_a(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("a_idle_busy", busy_a, 0);
            chk("a_idle_valid", valid_a, 0);
            chk("a_idle_sel", sel_a, 0);
        end
    endtask

    // One scan on A, started from a negedge. Start is hammered randomly while
    // busy; with jitter the mux inputs change randomly during the scan.
    task automatic scan_a(input logic [7:0] pat0, input bit jitter);
        logic [7:0] exp;
        exp     = 8'h00;
        pat_a   = pat0;
        start_a = 1'b1;
        for (int k = 1; k <= LA; k++) begin
            @(negedge clk);
            start_a = (k < LA) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (jitter && ($urandom_range(0, 3) == 0)) pat_a = 8'($urandom);
            for (int i = 0; i < 8; i++)
                if (k == (i + 1) * (SA + 1)) exp[i] = pat_a[i];
            chk("a_busy", busy_a, 1);
            chk("a_sel", sel_a, (k < LA) ? (k - 1) / (SA + 1) : 7);
            chk("a_valid", valid_a, (k == LA) ? 1 : 0);
            if (k == LA) begin
                chk("a_data", data_a, exp);
                chk("a_changed", chg_a, (exp != prev_a) ? 1 : 0);
                prev_a = exp;
            end else begin
                chk("a_changed_low", chg_a, 0);
            end
        end
        @(negedge clk);
        chk("a_busy_after", busy_a, 0);
        chk("a_valid_after", valid_a, 0);
        chk("a_sel_after", sel_a, 0);
        chk("a_data_hold", data_a, prev_a);
    endtask

    initial begin
        bit found;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; cont_a = 1'b0; cont_b = 1'b0;
        pat_a = 8'h00; pat_b = 8'h00;
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rst_sel", sel_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_changed", chg_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_b_busy", busy_b, 0);

        // Release and start on the very first edge; inputs 1 on sel 0,3,7.
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        scan_a(8'h89, 1'b0);
        scan_a(8'h89, 1'b0);
        idle_a(2);

        // Randomized scans with inputs moving during the scan.
        for (int n = 0; n < 6; n++) begin
            scan_a(8'($urandom), n[0]);
            idle_a($urandom_range(0, 3));
        end

        // Reset while mux_sel is 4: outputs clear at once, no valid follows.
        pat_a   = 8'($urandom) | 8'h01;
        start_a = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (sel_a == 3'd4) found = 1'b1;
        end
        chk("a_reach_sel4", found, 1);
        #2 rst_a = 1'b0;
        #1;
        chk("arst_sel", sel_a, 0);
        chk("arst_data", data_a, 0);
        chk("arst_valid", valid_a, 0);
        chk("arst_changed", chg_a, 0);
        chk("arst_busy", busy_a, 0);
        prev_a = 8'h00;
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < LA + 5; k++) begin
            @(negedge clk);
            chk("arel_valid", valid_a, 0);
            chk("arel_data", data_a, 0);
            chk("arel_busy", busy_a, 0);
        end
        scan_a(8'($urandom) | 8'h10, 1'b0);

        // Continuous mode on B with no settle time, dropped mid fourth scan.
        pat_b   = 8'hFF;
        cont_b  = 1'b1;
        start_b = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            int p;
            @(negedge clk);
            start_b = 1'b0;
            if (c == 3 * LB + 4) cont_b = 1'b0;
            p = ((c - 1) % LB) + 1;
            chk("b_valid", valid_b, ((c % LB == 0) && (c <= 4 * LB)) ? 1 : 0);
            chk("b_busy", busy_b, (c <= 4 * LB) ? 1 : 0);
            if (c <= 4 * LB)
                chk("b_sel", sel_b, (p < LB) ? p - 1 : 7);
            else
                chk("b_sel_idle", sel_b, 0);
            if ((c % LB == 0) && (c <= 4 * LB)) begin
                chk("b_data", data_b, 8'hFF);
                chk("b_changed", chg_b, (c == LB) ? 1 : 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", nchk);
        $fatal(1, "timeout");
    end

endmodule
